microsequencer: RTL
===================

# microsequencer

Next-address unit for the MIC-1 microarchitecture, on the consuming end of the ALU flag interface. Each cycle it takes the N/Z flags produced by the ALU, the branch and jump fields of the current microinstruction, and the MBR byte. It registers the next microprogram counter (MPC) that addresses the control store. It also provides a start/halt state machine and a memory-wait stall, so the datapath can be frozen without losing sequencing state.

## Interface
Parameters:
- MPC_BITS, 9, control-store address width; bit MPC_BITS-1 is the JAM bit.
- MBR_BITS, 8, MBR width; must equal MPC_BITS-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; leaves IDLE or HALT.
- stall  in  1  memory wait; freezes all state while high.
- n_in  in  1  ALU negative flag for the current microinstruction.
- z_in  in  1  ALU zero flag for the current microinstruction.
- next_addr  in  MPC_BITS  NEXT_ADDRESS field of the current microinstruction.
- jmpc  in  1  JMPC field.
- jamn  in  1  JAMN field.
- jamz  in  1  JAMZ field.
- halt  in  1  halt field of the current microinstruction.
- mbr  in  MBR_BITS  MBR contents.
- mpc  out  MPC_BITS  registered control-store address.
- n_q  out  1  registered N flag.
- z_q  out  1  registered Z flag.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- ucount  out  32  count of executed microinstructions (see Configuration).

## Operation
- The control store is combinational from mpc, so microinstruction fields are valid in the same cycle as mpc.
- States:
  - IDLE (after reset):
    - start=1 → RUN; mpc stays 0.
    - All other inputs are ignored.
  - RUN, stall=1:
    - Hold mpc, n_q, z_q, ucount and state.
    - halt and start are ignored.
  - RUN, stall=0, halt=0 (an executed microinstruction):
    - mpc <= addr.
    - n_q <= n_in, z_q <= z_in.
    - ucount increments.
  - RUN, stall=0, halt=1 → HALT:
    - mpc, n_q and z_q hold.
    - ucount increments; the halt microinstruction counts.
  - HALT:
    - start=1 (with stall=0) → RUN; mpc <= addr computed from the current fields and n_in/z_in.
    - Otherwise hold.
- Next-address computation (combinational, OR semantics):
  - addr = next_addr.
  - addr[MPC_BITS-1] |= (jamn & n_in) | (jamz & z_in).
  - If jmpc: addr[MBR_BITS-1:0] |= mbr.
  - jmpc, jamn and jamz may all be active; their results OR together. There is no precedence and no error.
- Branching uses the flags of the same microinstruction (n_in/z_in), not n_q/z_q. n_q/z_q are for observation only.
- ucount wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values: mpc=0, n_q=0, z_q=0, running=0, halted=0, ucount=0, state IDLE.
- rst_n low clears all state immediately, regardless of clk, including mid-RUN and during a stall. Sequencing restarts from IDLE.
- Latency:
  - Microinstruction fields present in cycle k → new mpc visible after edge k.
  - A taken JAM or JMPC branch costs no extra cycles.
- A stall asserted in cycle k suppresses the update at edge k. The fields must be held stable by the source until stall drops.
- running and halted are registered and update at the same edge as the state transition. They are never both high.
- start during RUN has no effect. start in IDLE or HALT coinciding with stall=1 is ignored and must be re-pulsed.

## Configuration
- MICROSEQ_UCOUNT_EN defined:
  - ucount is a 32-bit register, incrementing as specified in Operation.
- Not defined:
  - ucount is tied to 0.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- Reset then start: rst_n low→high, start pulse → running=1 the next cycle, mpc=0x000, ucount=0 (macro on).
- Plain sequencing: next_addr=0x012, all jams 0 → mpc=0x012 after one edge; ucount=1.
- JAMZ/JAMN:
  - next_addr=0x092, jamz=1, z_in=1 → mpc=0x192.
  - Same with z_in=0 → mpc=0x092.
  - jamn=1, n_in=1, next_addr=0x100 → mpc=0x100.
- JMPC: next_addr=0x000, jmpc=1, mbr=0x10 → mpc=0x010. Same with next_addr=0x001, mbr=0x10 → mpc=0x011.
- Stall and halt:
  - Assert stall for 3 cycles with next_addr=0x055 → mpc, n_q, z_q and ucount unchanged, then mpc=0x055 one edge after stall drops.
  - halt=1 → halted=1 with mpc held.
  - start then → mpc=addr and running=1.
- Async reset mid-run: drop rst_n between edges while mpc=0x0A3 → mpc=0, all flags 0, state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/microsequencer.sv
// MIC-1 next-address unit: registered MPC with JAM/JMPC branching, start/halt FSM and stall.
// Define MICROSEQ_UCOUNT_EN to build the 32-bit executed-microinstruction counter on ucount.
module microsequencer #(
  parameter int MPC_BITS = 9,
  parameter int MBR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stall,
  input  logic                n_in,
  input  logic                z_in,
  input  logic [MPC_BITS-1:0] next_addr,
  input  logic                jmpc,
  input  logic                jamn,
  input  logic                jamz,
  input  logic                halt,
  input  logic [MBR_BITS-1:0] mbr,
  output logic [MPC_BITS-1:0] mpc,
  output logic                n_q,
  output logic                z_q,
  output logic                running,
  output logic                halted,
  output logic [31:0]         ucount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [MPC_BITS-1:0] addr;
  logic [MPC_BITS-1:0] mpc_d;
  logic                n_d;
  logic                z_d;
  logic                jam_bit;

  // Branch sources OR together with no precedence; the JAM bit is the MSB.
  always_comb begin
    jam_bit = (jamn & n_in) | (jamz & z_in);
    addr    = next_addr;
    addr[MPC_BITS-1] = addr[MPC_BITS-1] | jam_bit;
    if (jmpc) begin
      addr[MBR_BITS-1:0] = addr[MBR_BITS-1:0] | mbr;
    end
  end

  always_comb begin
    state_d = state_q;
    mpc_d   = mpc;
    n_d     = n_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stall) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = HALT;
          end else begin
            mpc_d = addr;
            n_d   = n_in;
            z_d   = z_in;
          end
        end
      end
      HALT: begin
        if (start && !stall) begin
          state_d = RUN;
          mpc_d   = addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mpc     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      mpc     <= mpc_d;
      n_q     <= n_d;
      z_q     <= z_d;
      running <= (state_d == RUN);
      halted  <= (state_d == HALT);
    end
  end

`ifdef MICROSEQ_UCOUNT_EN
  // Every unstalled RUN cycle retires one microinstruction, the halt itself included.
  logic        count_inc;
  logic [31:0] count_q;

  assign count_inc = (state_q == RUN) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (count_inc) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign ucount = count_q;
`else
  assign ucount = '0;
`endif

endmodule
